// File: rtl/data_memory_sized.sv
// rtl/data_memory_sized.sv - byte/half/word data memory with handshake, faults and clear sweep
module data_memory_sized #(
  parameter int DEPTH_WORDS    = 64,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_address,
  input  logic [31:0] req_write_data,
  output logic        resp_valid,
  output logic        resp_fault,
  output logic [31:0] read_data,
  output logic        busy_clearing
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH_WORDS - 1);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] clear_cnt_q, clear_cnt_d;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          resp_valid_q, resp_fault_q;
  logic [31:0]   read_data_q;

  logic          accept, fault;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word, lane_shift, load_data, wr_lanes;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [3:0]    byte_en;

  assign accept   = req_valid & req_ready;
  assign word_idx = req_address[AW+1:2];

  always_comb begin
    fault = 1'b0;
    if (req_size == 2'b11) fault = 1'b1;
    if (req_size == 2'b01 && req_address[0]) fault = 1'b1;
    if (req_size == 2'b10 && req_address[1:0] != 2'b00) fault = 1'b1;
    if ((req_address >> (AW + 2)) != 32'd0) fault = 1'b1;
  end

  // Load path: select lane(s) from the addressed word and extend to 32 bits.
  assign rd_word    = mem[word_idx];
  assign lane_shift = rd_word >> {req_address[1:0], 3'b000};
  assign byte_sel   = lane_shift[7:0];
  assign half_sel   = req_address[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = rd_word;
    case (req_size)
      2'b00:   load_data = {{24{~req_unsigned & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{~req_unsigned & half_sel[15]}}, half_sel};
      default: load_data = rd_word;
    endcase
  end

  // Store path: replicate right-justified data onto every lane, then enable the addressed ones.
  always_comb begin
    byte_en  = 4'b0000;
    wr_lanes = req_write_data;
    case (req_size)
      2'b00: begin
        byte_en  = 4'b0001 << req_address[1:0];
        wr_lanes = {4{req_write_data[7:0]}};
      end
      2'b01: begin
        byte_en  = req_address[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{req_write_data[15:0]}};
      end
      2'b10:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  always_ff @(posedge clock) begin
    if (state_q == S_CLEAR) begin
      mem[clear_cnt_q] <= '0;
    end else if (accept && req_write && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      clear_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_cnt_q <= clear_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clear_cnt_d = clear_cnt_q;
    if (state_q == S_CLEAR) begin
      clear_cnt_d = clear_cnt_q + AW'(1);
      if (clear_cnt_q == LAST_WORD) state_d = S_IDLE;
    end
  end

  always_comb begin
    req_ready     = (state_q == S_IDLE);
    busy_clearing = (state_q == S_CLEAR);
  end

  // Fault and data registers only move on acceptance so they hold between responses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      read_data_q  <= '0;
    end else begin
      resp_valid_q <= accept;
      if (accept) begin
        resp_fault_q <= fault;
        read_data_q  <= (fault || req_write) ? 32'd0 : load_data;
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_fault = resp_fault_q;
  assign read_data  = read_data_q;

endmodule

// File: doc/data_memory_sized.md
Name: data_memory_sized

Overview:
- Parametrised successor to the single-cycle word data memory. Adds byte/half/word load-store with sign/zero extension and little-endian byte lanes.
- Adds a valid/ready request handshake, a registered 1-cycle read response, misalignment and out-of-range fault reporting, and an optional zero-clear sweep after reset.
- Sits between the core's load/store unit and the writeback mux.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words; must be a power of two, at least 2.
- CLEAR_ON_RESET, 1, 1 = sweep all words to zero after reset before accepting requests; 0 = no sweep, contents undefined after reset.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_address  input  32  byte address.
- req_write_data  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- resp_valid  output  1  one-cycle pulse; response for the request accepted on the previous edge.
- resp_fault  output  1  qualified by resp_valid; request was rejected.
- read_data  output  32  qualified by resp_valid; extended load data.
- busy_clearing  output  1  high while the clear sweep runs.

Behaviour:
- Reset (async, any time, including mid-sweep or with a response pending) sets the outputs and state as follows:
  - resp_valid=0, resp_fault=0, read_data=0.
  - Clear counter = 0.
  - State = CLEAR if CLEAR_ON_RESET=1, else IDLE.
  - A reset during a sweep restarts the sweep from word 0.
- States are CLEAR and IDLE only.
- CLEAR state:
  - req_ready=0, busy_clearing=1.
  - Each cycle writes 0 to word[clear_cnt] and increments clear_cnt.
  - After writing word DEPTH_WORDS-1, goes to IDLE; the sweep takes exactly DEPTH_WORDS cycles.
  - No responses are generated in CLEAR.
- IDLE state: req_ready=1, busy_clearing=0. A request is accepted on the edge where req_valid & req_ready. Throughput is one request per cycle; the response has no backpressure.
- Word index is req_address[log2(DEPTH_WORDS)+1:2].
- Fault conditions (any one rejects the request):
  - req_size=11.
  - Half access with address[0]=1.
  - Word access with address[1:0]≠00.
  - Any of address[31:log2(DEPTH_WORDS)+2] nonzero.
  - A faulting store writes nothing.
  - Any faulting request returns resp_fault=1, read_data=0.
- Store (accepted, no fault):
  - Byte lanes are written at the accepting edge.
  - Byte: lane address[1:0] ← wdata[7:0].
  - Half: lanes {a1,0},{a1,1} ← wdata[15:0] (little-endian).
  - Word: all lanes.
  - Unselected lanes are untouched.
  - Next cycle: resp_valid=1, resp_fault=0, read_data=0.
- Load (accepted, no fault):
  - The array is read at the accepting edge (synchronous read).
  - Next cycle: resp_valid=1, resp_fault=0.
  - read_data = selected byte/half, shifted to bit 0 and sign- or zero-extended per req_unsigned; word returns unchanged.
- Latency is exactly 1 cycle from acceptance to resp_valid. resp_valid=0 in any cycle following no acceptance.
- Store at cycle N followed by a load of the same word at N+1 returns the stored data (storage updated at edge N).
- Outputs hold their last values when resp_valid=0 except resp_valid itself. The bench checks data only when resp_valid=1.

Test Plan:
- Sweep and handshake: reset with CLEAR_ON_RESET=1, DEPTH_WORDS=64 → req_ready=0 and busy_clearing=1 for exactly 64 cycles; then a load at 0x00 returns 0x00000000. Assert reset at sweep cycle 20 → sweep restarts, 64 more cycles.
- Word round-trip: store word 0xDEADBEEF @0x10, then load word @0x10 on the next cycle → resp_valid one cycle after each acceptance, read_data=0xDEADBEEF, fault=0.
- Byte store and extension:
  - Store byte 0x80 @0x11 over 0xDEADBEEF → word reads 0xDEAD80EF.
  - Load byte signed @0x11 → 0xFFFFFF80.
  - Load byte unsigned @0x11 → 0x00000080.
- Half access:
  - Store half 0x1234 @0x22 → word @0x20 = 0x1234xxxx with the low half unchanged.
  - Load half signed @0x22 → 0x00001234.
  - Store half 0x8001, then signed load → 0xFFFF8001.
- Faults:
  - Word @0x12 → fault.
  - Half @0x13 → fault.
  - req_size=11 → fault.
  - Word @0x100 (DEPTH 64) → fault.
  - Each faulting request returns read_data=0, and a subsequent load shows memory unchanged.
- Back-to-back: 8 consecutive accepted requests with req_valid held high → 8 consecutive resp_valid pulses in order, no bubbles. Deasserting req_valid for one cycle → exactly one resp_valid=0 gap.
